// File: rtl/tt_sweep_ctrl_if.sv
// tt_sweep_ctrl_if
// Groups the host-side start/busy/done handshake and the function-unit
// connection (x, y, s) of tt_sweep_ctrl.
//   master : host / bench side. Drives start, abort, expected and the unit output s.
//   slave  : the sweep controller. Drives x, y, busy, done, table_o, match, first_err.
interface tt_sweep_ctrl_if;
    logic       start;
    logic       abort;
    logic [3:0] expected;
    logic       s;
    logic       x;
    logic       y;
    logic       busy;
    logic       done;
    logic [3:0] table_o;
    logic       match;
    logic [1:0] first_err;

    modport master (
        output start, abort, expected, s,
        input  x, y, busy, done, table_o, match, first_err
    );

    modport slave (
        input  start, abort, expected, s,
        output x, y, busy, done, table_o, match, first_err
    );
endinterface

// File: rtl/tt_sweep_ctrl.sv
// tt_sweep_ctrl
// Steps a 2-input combinational function unit through rows {x,y} = 0..3.
// Each row is held SETTLE cycles, then the unit output s is sampled into
// table_o[row]. At the end the captured table is compared with the golden
// table latched at start, and match / first_err are reported alongside a
// one-cycle done pulse.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : tt_sweep_ctrl_if.slave
//            in : start, abort, expected[3:0], s
//            out: x, y, busy, done, table_o[3:0], match, first_err[1:0]
// Parameter:
//   SETTLE : cycles each row is held before sampling (1..15)
module tt_sweep_ctrl #(
    parameter int unsigned SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    tt_sweep_ctrl_if.slave  bus
);

    localparam logic [3:0] LP_SETTLE = 4'(SETTLE);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [1:0] r_row,   w_row_nxt;
    logic [3:0] r_cnt,   w_cnt_nxt;
    logic [3:0] r_exp,   w_exp_nxt;
    logic [3:0] r_table, w_table_nxt;
    logic       r_match, w_match_nxt;
    logic [1:0] r_ferr,  w_ferr_nxt;

    logic [3:0] w_sampled;   // table with the current row's s merged in
    logic [3:0] w_diff;
    logic [1:0] w_ferr_calc;
    logic       w_busy;

    // Table as it will look after this cycle's sample edge.
    always_comb begin
        w_sampled        = r_table;
        w_sampled[r_row] = bus.s;
    end

    // Lowest differing row; 0 when the tables agree.
    always_comb begin
        w_diff = w_sampled ^ r_exp;
        if (w_diff[0])      w_ferr_calc = 2'd0;
        else if (w_diff[1]) w_ferr_calc = 2'd1;
        else if (w_diff[2]) w_ferr_calc = 2'd2;
        else if (w_diff[3]) w_ferr_calc = 2'd3;
        else                w_ferr_calc = 2'd0;
    end

    // Next-state and datapath updates.
    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_cnt_nxt   = r_cnt;
        w_exp_nxt   = r_exp;
        w_table_nxt = r_table;
        w_match_nxt = r_match;
        w_ferr_nxt  = r_ferr;

        case (r_state)
            ST_IDLE: begin
                // abort has priority over a simultaneous start
                if (bus.start && !bus.abort) begin
                    w_state_nxt = ST_SETTLE;
                    w_row_nxt   = 2'd0;
                    w_cnt_nxt   = LP_SETTLE;
                    w_exp_nxt   = bus.expected;
                    w_table_nxt = 4'd0;
                    w_match_nxt = 1'b0;
                    w_ferr_nxt  = 2'd0;
                end
            end

            ST_SETTLE: begin
                if (bus.abort) begin
                    w_state_nxt = ST_IDLE;
                    w_match_nxt = 1'b0;
                    w_ferr_nxt  = 2'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                    // <= guards against a count that somehow reached 0
                    if (r_cnt <= 4'd1) begin
                        w_state_nxt = ST_SAMPLE;
                    end
                end
            end

            ST_SAMPLE: begin
                if (bus.abort) begin
                    // no sample on the abort edge; earlier rows are kept
                    w_state_nxt = ST_IDLE;
                    w_match_nxt = 1'b0;
                    w_ferr_nxt  = 2'd0;
                end else begin
                    w_table_nxt = w_sampled;
                    if (r_row == 2'd3) begin
                        w_state_nxt = ST_DONE;
                        w_match_nxt = (w_sampled == r_exp);
                        w_ferr_nxt  = w_ferr_calc;
                    end else begin
                        w_state_nxt = ST_SETTLE;
                        w_row_nxt   = r_row + 2'd1;
                        w_cnt_nxt   = LP_SETTLE;
                    end
                end
            end

            ST_DONE: begin
                // start and abort are both ignored here
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_row   <= 2'd0;
            r_cnt   <= 4'd0;
            r_exp   <= 4'd0;
            r_table <= 4'd0;
            r_match <= 1'b0;
            r_ferr  <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
            r_cnt   <= w_cnt_nxt;
            r_exp   <= w_exp_nxt;
            r_table <= w_table_nxt;
            r_match <= w_match_nxt;
            r_ferr  <= w_ferr_nxt;
        end
    end

    // Outputs decode straight from registered state, so reset clears
    // them immediately without a clock edge.
    assign w_busy        = (r_state == ST_SETTLE) || (r_state == ST_SAMPLE);
    assign bus.busy      = w_busy;
    assign bus.done      = (r_state == ST_DONE);
    assign bus.x         = w_busy & r_row[1];
    assign bus.y         = w_busy & r_row[0];
    assign bus.table_o   = r_table;
    assign bus.match     = r_match;
    assign bus.first_err = r_ferr;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Bench for tt_sweep_ctrl: two instances (SETTLE=1 and SETTLE=3) share the
// stimulus; sel picks which one is driven and observed. The function unit
// is a truth-table lookup (lut) so random units can be swept.
module tb_tt_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       sel = 1'b0;
    logic [3:0] expected = 4'd0;
    logic [3:0] lut = 4'b0010;   // s = y & ~x
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    tt_sweep_ctrl_if if1 ();
    tt_sweep_ctrl_if if3 ();

    assign if1.start    = start & ~sel;
    assign if3.start    = start & sel;
    assign if1.abort    = abort;
    assign if3.abort    = abort;
    assign if1.expected = expected;
    assign if3.expected = expected;
    assign if1.s        = lut[{if1.x, if1.y}];
    assign if3.s        = lut[{if3.x, if3.y}];

    tt_sweep_ctrl #(.SETTLE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    tt_sweep_ctrl #(.SETTLE(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

    logic       ox, oy, obusy, odone, omatch;
    logic [3:0] otab;
    logic [1:0] oferr;
    assign ox     = sel ? if3.x         : if1.x;
    assign oy     = sel ? if3.y         : if1.y;
    assign obusy  = sel ? if3.busy      : if1.busy;
    assign odone  = sel ? if3.done      : if1.done;
    assign omatch = sel ? if3.match     : if1.match;
    assign otab   = sel ? if3.table_o   : if1.table_o;
    assign oferr  = sel ? if3.first_err : if1.first_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_ferr(input logic [3:0] t, input logic [3:0] e);
        for (int i = 0; i < 4; i++)
            if (t[i] != e[i]) return 2'(i);
        return 2'd0;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_x"},     32'(ox), 0);
        chk({tag, "_y"},     32'(oy), 0);
        chk({tag, "_busy"},  32'(obusy), 0);
        chk({tag, "_done"},  32'(odone), 0);
        chk({tag, "_tab"},   32'(otab), 0);
        chk({tag, "_match"}, 32'(omatch), 0);
        chk({tag, "_ferr"},  32'(oferr), 0);
    endtask

    // One sweep on the selected instance. ab_cyc: 0 = none, 1..N = abort
    // asserted during that cycle, N+1 = abort during the done cycle.
    // tog: scramble start/expected while the sweep runs.
    task automatic sweep(input logic [3:0] e, input int ab_cyc, input bit tog);
        int R, N, row;
        logic [3:0] part;
        R = sel ? 4 : 2;
        N = 4 * R;
        @(negedge clk);
        expected = e;
        start = 1'b1;
        abort = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= N + 1; c++) begin
            @(negedge clk);
            if (c <= N) begin
                row = (c - 1) / R;
                chk("busy", 32'(obusy), 1);
                chk("done_early", 32'(odone), 0);
                chk("x", 32'(ox), 32'(row[1]));
                chk("y", 32'(oy), 32'(row[0]));
            end else begin
                chk("done", 32'(odone), 1);
                chk("busy_done", 32'(obusy), 0);
                chk("x_done", 32'(ox), 0);
                chk("y_done", 32'(oy), 0);
                chk("table", 32'(otab), 32'(lut));
                chk("match", 32'(omatch), 32'(lut == e));
                chk("ferr", 32'(oferr), 32'(ref_ferr(lut, e)));
            end
            if (tog) begin
                start = 1'($urandom % 2);
                expected = 4'($urandom);
            end
            if (c == ab_cyc && c <= N) begin
                abort = 1'b1;
                start = 1'b0;
                @(posedge clk);
                #1 abort = 1'b0;
                // rows whose sample edge came before the abort edge
                for (int r = 0; r < 4; r++)
                    part[r] = ((r + 1) * R <= c - 1) ? lut[r] : 1'b0;
                @(negedge clk);
                chk("ab_busy", 32'(obusy), 0);
                chk("ab_x", 32'(ox), 0);
                chk("ab_y", 32'(oy), 0);
                chk("ab_match", 32'(omatch), 0);
                chk("ab_ferr", 32'(oferr), 0);
                chk("ab_table", 32'(otab), 32'(part));
                for (int k = 0; k < N + 2; k++) begin
                    chk("ab_nodone", 32'(odone), 0);
                    @(negedge clk);
                end
                chk("ab_idle", 32'(obusy), 0);
                return;
            end else if (c == ab_cyc) begin
                abort = 1'b1;
                start = 1'b0;
                @(posedge clk);
                #1 abort = 1'b0;
            end
        end
        @(negedge clk);
        start = 1'b0;
        chk("idle_busy", 32'(obusy), 0);
        chk("idle_done", 32'(odone), 0);
        chk("hold_table", 32'(otab), 32'(lut));
        chk("hold_match", 32'(omatch), 32'(lut == e));
        chk("hold_ferr", 32'(oferr), 32'(ref_ferr(lut, e)));
        @(negedge clk);
        chk("no_restart", 32'(obusy), 0);
    endtask

    initial begin
        int n, ab;
        logic [3:0] e;
        bit tog;

        // reset state
        #12;
        sel = 1'b0;
        chk_all_zero("rst1");
        sel = 1'b1;
        #1 chk_all_zero("rst3");
        @(negedge clk);
        rst_n = 1'b1;
        sel = 1'b0;

        // directed sweeps with s = y & ~x
        lut = 4'b0010;
        sweep(4'b0010, 0, 1'b0);
        sweep(4'b0110, 0, 1'b0);
        sweep(4'b0011, 0, 1'b0);
        sel = 1'b1;
        sweep(4'b0010, 0, 1'b0);
        sweep(4'b0010, 0, 1'b1);
        sel = 1'b0;
        sweep(4'b0010, 5, 1'b0);   // abort during row 2 settle
        sweep(4'b0010, 9, 1'b0);   // abort in done cycle: no effect

        // start and abort together in IDLE
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        abort = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("sa_busy", 32'(obusy), 0);
        end

        // reset during row 1
        @(negedge clk);
        expected = 4'b0010;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_y", 32'(oy), 1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("post_rst_idle", 32'(obusy), 0);
        end
        sweep(4'b0010, 0, 1'b0);

        // randomized sweeps
        for (int it = 0; it < 24; it++) begin
            sel = 1'($urandom % 2);
            lut = 4'($urandom);
            e   = ($urandom % 3 == 0) ? lut : 4'($urandom);
            n   = sel ? 16 : 8;
            ab  = ($urandom % 4 == 0) ? int'($urandom_range(1, n + 1)) : 0;
            tog = 1'($urandom % 2);
            sweep(e, ab, tog);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tt_sweep_ctrl.md
# tt_sweep_ctrl

Sequencer that drives a 2-input combinational function unit, such as the lab's `f(x,y)` gate network, through all four input rows. At each row it waits a programmable settle time, samples the unit's output `s`, and assembles a 4-bit truth table. It then compares that table against a golden table captured at start and reports match or first mismatching row through a start/busy/done handshake. The block sits between the bench or host logic and the function unit under test, and it owns the unit's `x`/`y` inputs exclusively.

## Interface
- `SETTLE`, default 1, cycles each row is held before sampling; legal range 1..15.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  level sampled per cycle; begins a sweep when accepted in IDLE.
- `abort`  in  1  terminates a sweep in progress; no done pulse.
- `expected`  in  4  golden table, bit i = required `s` for row i = {x,y}; latched on start.
- `s`  in  1  output of the function unit.
- `x`  out  1  function-unit input; equals row[1].
- `y`  out  1  function-unit input; equals row[0].
- `busy`  out  1  high in SETTLE and SAMPLE states.
- `done`  out  1  one-cycle pulse at sweep completion.
- `table_o`  out  4  captured table, bit i = `s` sampled for row i.
- `match`  out  1  `table_o == expected` for the last completed sweep.
- `first_err`  out  2  lowest row index where table and expected differ; 0 when `match`=1.

## Operation
- Internal state: state reg (IDLE, SETTLE, SAMPLE, DONE), 2-bit `row`, 4-bit settle counter `cnt`, 4-bit `exp_q`.
- **IDLE** drives `x`=`y`=0.
  - `start`=1 and `abort`=0: row←0, cnt←SETTLE, exp_q←`expected`, table_o←0, match←0, first_err←0, go to SETTLE.
  - `abort`=1 wins over a simultaneous `start`; the block stays in IDLE.
- **SETTLE**
  - `{x,y}` = row.
  - cnt decrements each cycle; when cnt==1, go to SAMPLE.
  - Each row therefore spends exactly SETTLE cycles here.
- **SAMPLE**
  - `{x,y}` = row held.
  - On the clock edge, table_o[row] ← `s`.
  - If row==3, go to DONE. Otherwise row←row+1, cnt←SETTLE, go to SETTLE.
- **DONE**
  - `done`=1 for exactly one cycle, `busy`=0, `{x,y}`=0.
  - Go to IDLE unconditionally.
  - `start` seen in DONE is ignored; a new sweep needs `start` in IDLE.
- **Result computation**
  - match and first_err are registered on the edge leaving the final SAMPLE.
  - They are computed from the final table {s, table_o[2:0]} and exp_q, and are valid in the DONE cycle.
  - They hold until the next accepted start or an abort.
- **start while busy** is ignored; `expected` changes during a sweep have no effect.
- **abort in SETTLE or SAMPLE**
  - Next state is IDLE; no sample is taken that cycle; `done` is not pulsed.
  - match←0 and first_err←0; table_o keeps the rows already captured.
- **abort in DONE** has no effect; the done pulse still occurs.

## Timing
- Reset (asynchronous, immediate): state=IDLE, x=y=0, busy=0, done=0, table_o=0, match=0, first_err=0, row=0, cnt=0, exp_q=0.
- Reset mid-sweep: all outputs drop to their reset values without waiting for a clock edge. After release, the block idles until a new `start`.
- Let `start` be accepted on edge E0.
  - Edge E0 moves the block into row 0; `busy` is high from the cycle after E0.
  - Each row occupies SETTLE+1 cycles.
  - The sweep occupies 4·(SETTLE+1) cycles.
  - `done` is high in cycle 4·(SETTLE+1)+1 after E0.
  - With SETTLE=1: busy for cycles 1–8, done in cycle 9.
- Minimum spacing between accepted starts is 4·(SETTLE+1)+2 cycles.
- `s` must be stable SETTLE cycles after `{x,y}` changes. The block adds no synchronizer on `s`.

## Test plan
- **Reset-only check**, with the unit `s = y & ~x` attached: with rst_n low, all outputs are 0 (covers the reset-value requirement).
- **Passing sweep**, with `s = y & ~x`, SETTLE=1, expected=4'b0010, pulse start:
  - x,y step 00→01→10→11, two cycles each.
  - done in cycle 9; table_o=4'b0010, match=1, first_err=0.
- **Failing sweep**, same unit, expected=4'b0110:
  - table_o=4'b0010, match=0, first_err=2.
  - Repeat with expected=4'b0011: first_err=0, match=0.
- **Settle timing**, SETTLE=3, expected=4'b0010:
  - each row held 4 cycles, done in cycle 17, match=1.
  - Toggle `start` and `expected` during the sweep: no restart, result unchanged.
- **Abort mid-sweep**:
  - Assert abort during row 2 SETTLE: IDLE next cycle, x=y=0, no done pulse, match=0, table_o=4'b0010 (rows 0–1 captured).
  - Drive start and abort together in IDLE: the block stays idle.
- **Reset mid-sweep**:
  - Drop rst_n during row 1: outputs zero asynchronously.
  - After release, a new start completes normally with done in cycle 9.
